ram_dual_port_be: RTL and testbench

- Parametrised successor to the single-port 64x32 RAM.
- Simple dual-port memory: one write port with per-byte enables, one independent read port with registered output and valid flag.
- Selectable read-during-write collision mode.
- Built-in sequential clear engine zeroes the whole array after reset or on request.
- Used as the general data/scratch memory behind the datapath, wherever deterministic contents after reset are needed.

---
 rtl/ram_pkg.sv | 28 ++
 rtl/ram_dual_port_be_if.sv | 28 ++
 rtl/ram_clear_seq.sv | 60 ++++++
 rtl/ram_dual_port_be.sv | 83 ++++++++
 tb/tb_ram_dual_port_be.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types, collision-mode constants and byte-merge helper for ram_dual_port_be
package ram_pkg;

    typedef enum logic {CLEAR, IDLE} ram_state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Widest word the merge helper handles; callers zero-extend narrower words.
    localparam int MERGE_MAX_W = 1024;

    // Returns old_word with every byte lane whose mask bit is set replaced by new_word.
    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0]   old_word,
        input logic [MERGE_MAX_W-1:0]   new_word,
        input logic [MERGE_MAX_W/8-1:0] mask
    );
        logic [MERGE_MAX_W-1:0] result;
        result = old_word;
        for (int b = 0; b < MERGE_MAX_W/8; b++) begin
            if (mask[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_dual_port_be_if.sv
// rtl/ram_dual_port_be_if.sv - user-side bus of ram_dual_port_be
// Ports: clear_req/busy (clear control), write_enable/wr_adress/byte_en/data_in (write port),
//        rd_en/rd_adress (read request), data_out/rd_valid (registered read result).
interface ram_dual_port_be_if #(
    parameter int N = 6,
    parameter int M = 32
);
    logic           clear_req;
    logic           busy;
    logic           write_enable;
    logic [N-1:0]   wr_adress;
    logic [M/8-1:0] byte_en;
    logic [M-1:0]   data_in;
    logic           rd_en;
    logic [N-1:0]   rd_adress;
    logic [M-1:0]   data_out;
    logic           rd_valid;

    modport master (
        output clear_req, write_enable, wr_adress, byte_en, data_in, rd_en, rd_adress,
        input  busy, data_out, rd_valid
    );

    modport slave (
        input  clear_req, write_enable, wr_adress, byte_en, data_in, rd_en, rd_adress,
        output busy, data_out, rd_valid
    );
endinterface

// File: rtl/ram_clear_seq.sv
// rtl/ram_clear_seq.sv - clear engine sweeping zeros through the whole array
// Ports: clk, rst_n (async active-low), clear_req (start sweep from IDLE),
//        busy (sweep running), clr_we/clr_addr (array write request for the zero word).
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_req,
    output logic         busy,
    output logic         clr_we,
    output logic [N-1:0] clr_addr
);

    ram_state_t   state, state_nxt;
    logic [N-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt == {N{1'b1}}) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + N'(1);
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/ram_dual_port_be.sv
// rtl/ram_dual_port_be.sv - simple dual-port RAM with byte enables, registered read and clear engine
// Ports: clk, rst_n (async active-low), bus (ram_dual_port_be_if.slave: clear control,
//        byte-masked write port, read request, registered data_out/rd_valid).
// Parameters: N address width, M word width (multiple of 8), RDW_MODE collision behaviour.
module ram_dual_port_be
    import ram_pkg::*;
#(
    parameter int N        = 6,
    parameter int M        = 32,
    parameter int RDW_MODE = RDW_READ_FIRST
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_dual_port_be_if.slave   bus
);

    localparam int DEPTH = 2**N;

    logic         busy;
    logic         clr_we;
    logic [N-1:0] clr_addr;

    ram_clear_seq #(.N(N)) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (bus.clear_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    logic [M-1:0] mem [DEPTH];

    // A clear request in IDLE takes priority over any user access in the same cycle.
    logic wr_fire, rd_fire;
    assign wr_fire = !busy && !bus.clear_req && bus.write_enable;
    assign rd_fire = !busy && !bus.clear_req && bus.rd_en;

    logic [M-1:0]             wr_old;
    logic [M-1:0]             wr_merged;
    logic [MERGE_MAX_W-M-1:0] merge_unused;
    assign wr_old = mem[bus.wr_adress];
    assign {merge_unused, wr_merged} = byte_merge(MERGE_MAX_W'(wr_old),
                                                  MERGE_MAX_W'(bus.data_in),
                                                  (MERGE_MAX_W/8)'(bus.byte_en));

    // The array itself has no reset; the clear sweep provides deterministic contents.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_fire) begin
            mem[bus.wr_adress] <= wr_merged;
        end
    end

    logic collide;
    assign collide = wr_fire && (bus.wr_adress == bus.rd_adress);

    logic [M-1:0] data_out_q;
    logic         rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                // The same merged word being written forms the WRITE_FIRST bypass.
                if (RDW_MODE == RDW_WRITE_FIRST && collide) begin
                    data_out_q <= wr_merged;
                end else begin
                    data_out_q <= mem[bus.rd_adress];
                end
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_dual_port_be.sv
// tb/tb_ram_dual_port_be.sv - randomized self-checking bench for ram_dual_port_be (both collision modes)
module tb_ram_dual_port_be;

    localparam int N     = 4;
    localparam int M     = 32;
    localparam int DEPTH = 16;

    logic         clk;
    logic         rst_n;
    logic         clear_req;
    logic         we;
    logic [N-1:0] wa;
    logic [3:0]   be;
    logic [31:0]  din;
    logic         re;
    logic [N-1:0] ra;

    ram_dual_port_be_if #(.N(N), .M(M)) bus_rf ();
    ram_dual_port_be_if #(.N(N), .M(M)) bus_wf ();

    assign bus_rf.clear_req    = clear_req;
    assign bus_rf.write_enable = we;
    assign bus_rf.wr_adress    = wa;
    assign bus_rf.byte_en      = be;
    assign bus_rf.data_in      = din;
    assign bus_rf.rd_en        = re;
    assign bus_rf.rd_adress    = ra;
    assign bus_wf.clear_req    = clear_req;
    assign bus_wf.write_enable = we;
    assign bus_wf.wr_adress    = wa;
    assign bus_wf.byte_en      = be;
    assign bus_wf.data_in      = din;
    assign bus_wf.rd_en        = re;
    assign bus_wf.rd_adress    = ra;

    ram_dual_port_be #(.N(N), .M(M), .RDW_MODE(0)) u_rf (.clk(clk), .rst_n(rst_n), .bus(bus_rf));
    ram_dual_port_be #(.N(N), .M(M), .RDW_MODE(1)) u_wf (.clk(clk), .rst_n(rst_n), .bus(bus_wf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: word array plus remaining clear cycles.
    logic [31:0] mmem [DEPTH];
    int          clr_left;
    logic [31:0] e_rf, e_wf;
    logic        e_rv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] mask);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        clr_left = DEPTH;
        e_rf = '0;
        e_wf = '0;
        e_rv = 1'b0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    endtask

    task automatic compare_all();
        check("busy_rf", 32'(bus_rf.busy), 32'(clr_left > 0));
        check("busy_wf", 32'(bus_wf.busy), 32'(clr_left > 0));
        check("valid_rf", 32'(bus_rf.rd_valid), 32'(e_rv));
        check("valid_wf", 32'(bus_wf.rd_valid), 32'(e_rv));
        check("dout_rf", bus_rf.data_out, e_rf);
        check("dout_wf", bus_wf.data_out, e_wf);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (clr_left > 0) begin
            clr_left--;
            e_rv = 1'b0;
        end else if (clear_req) begin
            clr_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
            e_rv = 1'b0;
        end else begin
            if (re) begin
                e_rv = 1'b1;
                e_rf = mmem[ra];
                e_wf = (we && wa == ra) ? apply_be(mmem[ra], din, be) : mmem[ra];
            end else begin
                e_rv = 1'b0;
            end
            if (we) mmem[wa] = apply_be(mmem[wa], din, be);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        clear_req = 1'b0; we = 1'b0; wa = '0; be = '0; din = '0; re = 1'b0; ra = '0;
    endtask

    task automatic wr(input logic [N-1:0] a, input logic [31:0] d, input logic [3:0] m);
        idle(); we = 1'b1; wa = a; din = d; be = m;
        step();
    endtask

    task automatic rd(input logic [N-1:0] a);
        idle(); re = 1'b1; ra = a;
        step();
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_now_dout", bus_rf.data_out, 32'h0);
        check("rst_now_valid", 32'(bus_rf.rd_valid), 32'h0);
    endtask

    task automatic wait_sweep(input string tag, input int pulse_at);
        int n;
        n = 0;
        while (bus_rf.busy && n < 40) begin
            idle();
            clear_req = (n == pulse_at);
            step();
            n++;
        end
        check(tag, 32'(n), 32'd16);
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 compare_all();
        step();
        step();
        rst_n = 1'b1;
        wait_sweep("sweep_after_reset", -1);

        for (int i = 0; i < DEPTH; i++) rd(N'(i));
        idle(); step();

        wr(3, 32'hDEADBEEF, 4'b1111);
        wr(3, 32'h11223344, 4'b0101);
        rd(3);
        check("byte_merge", bus_rf.data_out, 32'hDE22BE44);

        wr(5, 32'hAAAAAAAA, 4'b1111);
        idle(); we = 1'b1; wa = 5; din = 32'h55555555; be = 4'b1111; re = 1'b1; ra = 5;
        step();
        check("coll_read_first", bus_rf.data_out, 32'hAAAAAAAA);
        check("coll_write_first", bus_wf.data_out, 32'h55555555);
        rd(5);
        check("after_coll", bus_rf.data_out, 32'h55555555);

        for (int i = 0; i < 400; i++) begin
            idle();
            clear_req = ($urandom_range(0, 59) == 0);
            we  = $urandom_range(0, 1) == 1;
            wa  = N'($urandom_range(0, DEPTH-1));
            be  = 4'($urandom_range(0, 15));
            din = $urandom;
            re  = $urandom_range(0, 1) == 1;
            ra  = ($urandom_range(0, 3) == 0) ? wa : N'($urandom_range(0, DEPTH-1));
            step();
        end
        idle();
        while (bus_rf.busy) step();

        for (int i = 0; i < DEPTH; i++) wr(N'(i), 32'h01010101 * (i + 1), 4'b1111);
        idle(); clear_req = 1'b1; we = 1'b1; wa = 7; din = 32'hFFFFFFFF; be = 4'hF; re = 1'b1; ra = 7;
        step();
        wait_sweep("clear_len_with_pulse", 4);
        for (int i = 0; i < DEPTH; i++) rd(N'(i));
        rd(7);
        check("clear_dropped_write", bus_rf.data_out, 32'h0);

        wr(9, 32'h12345678, 4'b1111);
        rd(9);
        check("read_9", bus_rf.data_out, 32'h12345678);
        idle(); step();
        check("hold_valid", 32'(bus_rf.rd_valid), 32'h0);
        check("hold_dout", bus_rf.data_out, 32'h12345678);

        idle(); clear_req = 1'b1; step();
        idle();
        repeat (8) step();
        assert_reset();
        step();
        step();
        rst_n = 1'b1;
        wait_sweep("sweep_after_mid_reset", -1);

        wr(2, 32'hCAFEF00D, 4'b1111);
        rd(2);
        check("read_2", bus_rf.data_out, 32'hCAFEF00D);
        idle(); re = 1'b1; ra = 2;
        assert_reset();
        step();
        rst_n = 1'b1;
        wait_sweep("sweep_after_read_reset", -1);
        rd(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
